// File: rtl/apu_frame_sequencer_if.sv
// Frame-sequencer register port and tick/IRQ outputs.
// The master drives the register writes; the slave (the sequencer) drives the ticks.
interface apu_frame_sequencer_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       irq_clear;
   logic       apu_clk_en;
   logic       qfr_tick;
   logic       hfr_tick;
   logic       frame_irq;
   logic [2:0] step;

   modport master (
      output wr_en, wr_data, irq_clear,
      input  apu_clk_en, qfr_tick, hfr_tick, frame_irq, step
   );

   modport slave (
      input  wr_en, wr_data, irq_clear,
      output apu_clk_en, qfr_tick, hfr_tick, frame_irq, step
   );
endinterface

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 4/5-step frame counter with quarter/half-frame ticks and frame IRQ.
// All outputs are registered; the ticks are decoded one cycle ahead from the next counter value.
module apu_frame_sequencer #(
   parameter int unsigned STEP_CYCLES = 7457
) (
   input logic                  clk,
   input logic                  rst_n,
   apu_frame_sequencer_if.slave bus
);
   localparam int unsigned CYC_W  = 16;
   localparam int unsigned STEP_W = 3;

   localparam logic [CYC_W-1:0] STEP1_END = CYC_W'(1 * STEP_CYCLES - 1);
   localparam logic [CYC_W-1:0] STEP2_END = CYC_W'(2 * STEP_CYCLES - 1);
   localparam logic [CYC_W-1:0] STEP3_END = CYC_W'(3 * STEP_CYCLES - 1);
   localparam logic [CYC_W-1:0] STEP4_END = CYC_W'(4 * STEP_CYCLES - 1);
   localparam logic [CYC_W-1:0] STEP5_END = CYC_W'(5 * STEP_CYCLES - 1);

   logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
   logic [STEP_W-1:0] step_q, step_d, fired;
   logic              mode_q, mode_d;
   logic              inh_q, inh_d;
   logic              irq_q, irq_d;
   logic              qfr_q, qfr_d;
   logic              hfr_q, hfr_d;
   logic              phase_q;
   logic              irq_now;
   logic              unused_wr_bits;

   assign unused_wr_bits = ^bus.wr_data[5:0];

   // Free-running counter advance and decode of the step that fires next cycle.
   always_comb begin
      cyc_inc = (cyc_q == (mode_q ? STEP5_END : STEP4_END)) ? '0 : cyc_q + CYC_W'(1);
      fired   = '0;
      if      (cyc_inc == STEP1_END) fired = STEP_W'(1);
      else if (cyc_inc == STEP2_END) fired = STEP_W'(2);
      else if (cyc_inc == STEP3_END) fired = STEP_W'(3);
      else if (cyc_inc == STEP4_END) fired = STEP_W'(4);
      else if (cyc_inc == STEP5_END) fired = STEP_W'(5);
      irq_now = !mode_q && !inh_q && (cyc_q == STEP4_END);
   end

   // Next-state: a register write restarts the frame and overrides the counter path.
   always_comb begin
      cyc_d  = cyc_inc;
      step_d = (cyc_inc == '0) ? '0 : step_q;
      mode_d = mode_q;
      inh_d  = inh_q;
      irq_d  = irq_q;
      qfr_d  = 1'b0;
      hfr_d  = 1'b0;

      if (bus.wr_en) begin
         cyc_d  = '0;
         step_d = '0;
         mode_d = bus.wr_data[7];
         inh_d  = bus.wr_data[6];
         qfr_d  = bus.wr_data[7];
         hfr_d  = bus.wr_data[7];
         if (bus.wr_data[6]) begin
            irq_d = 1'b0;
         end else if (bus.irq_clear && !irq_now) begin
            irq_d = 1'b0;
         end
      end else begin
         if (fired != '0) begin
            step_d = fired;
            qfr_d  = !(mode_q && fired == STEP_W'(4));
            hfr_d  = (fired == STEP_W'(2)) || (fired == STEP_W'(5)) ||
                     (fired == STEP_W'(4) && !mode_q);
         end
         // A set landing on the same edge as a clear wins.
         if (fired == STEP_W'(4) && !mode_q && !inh_q) begin
            irq_d = 1'b1;
         end else if (bus.irq_clear && !irq_now) begin
            irq_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q   <= '0;
         step_q  <= '0;
         mode_q  <= 1'b0;
         inh_q   <= 1'b0;
         irq_q   <= 1'b0;
         qfr_q   <= 1'b0;
         hfr_q   <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         inh_q   <= inh_d;
         irq_q   <= irq_d;
         qfr_q   <= qfr_d;
         hfr_q   <= hfr_d;
         phase_q <= ~phase_q;
      end
   end

   assign bus.apu_clk_en = phase_q;
   assign bus.qfr_tick   = qfr_q;
   assign bus.hfr_tick   = hfr_q;
   assign bus.frame_irq  = irq_q;
   assign bus.step       = step_q;
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: frame-position reference model compared every cycle,
// plus directed literal checks and randomized writes/acks/resets.
module tb_apu_frame_sequencer;
   localparam int S = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   apu_frame_sequencer_if bus();

   apu_frame_sequencer #(.STEP_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: position within the frame plus mode/inhibit/irq flags.
   int pos, m_nxt;
   bit m_mode, m_inh, m_irq, m_imm, m_phase, m_now4, m_nxt4;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_imm = 0; m_phase = 0;
      end else begin
         m_now4  = !m_mode && !m_inh && (pos + 1 == 4 * S);
         m_nxt   = (pos + 1) % ((m_mode ? 5 : 4) * S);
         m_nxt4  = !m_mode && !m_inh && (m_nxt + 1 == 4 * S);
         m_phase = !m_phase;
         if (bus.wr_en && bus.wr_data[6]) m_irq = 0;
         else if (!bus.wr_en && m_nxt4)   m_irq = 1;
         else if (bus.irq_clear && !m_now4) m_irq = 0;
         if (bus.wr_en) begin
            pos = 0; m_mode = bus.wr_data[7]; m_inh = bus.wr_data[6]; m_imm = bus.wr_data[7];
         end else begin
            pos = m_nxt; m_imm = 0;
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   int  e_k;
   bit  e_qfr, e_hfr;
   always @(negedge clk) begin
      e_k   = ((pos + 1) % S == 0) ? (pos + 1) / S : 0;
      e_qfr = m_imm || (e_k != 0 && !(m_mode && e_k == 4));
      e_hfr = m_imm || e_k == 2 || e_k == 5 || (e_k == 4 && !m_mode);
      check("model_qfr_tick",   8'(bus.qfr_tick),   8'(e_qfr));
      check("model_hfr_tick",   8'(bus.hfr_tick),   8'(e_hfr));
      check("model_step",       8'(bus.step),       8'((pos + 1) / S));
      check("model_frame_irq",  8'(bus.frame_irq),  8'(m_irq));
      check("model_apu_clk_en", 8'(bus.apu_clk_en), 8'(m_phase));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string name, input logic q, input logic h, input logic [2:0] s);
      check({name, "_qfr"},  8'(bus.qfr_tick), 8'(q));
      check({name, "_hfr"},  8'(bus.hfr_tick), 8'(h));
      check({name, "_step"}, 8'(bus.step),     8'(s));
   endtask

   task automatic release_reset;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bus.wr_en = 0; bus.wr_data = 0; bus.irq_clear = 0;
      #1 rst_n = 1'b0;
      cyc(2);
      lit("reset", 0, 0, 0);
      check("reset_irq", 8'(bus.frame_irq), 8'd0);
      check("reset_apu", 8'(bus.apu_clk_en), 8'd0);
      release_reset;                                   // cycle 0
      cyc(7);  lit("c7", 1, 0, 1);                     // cycle 7
      check("c7_apu", 8'(bus.apu_clk_en), 8'd1);
      cyc(8);  lit("c15", 1, 1, 2);                    // cycle 15
      cyc(16); lit("c31", 1, 1, 4);                    // cycle 31
      check("c31_irq", 8'(bus.frame_irq), 8'd1);
      bus.irq_clear = 1;
      cyc(1);  check("clr_at_step4_irq", 8'(bus.frame_irq), 8'd1);   // cycle 32
      check("c32_step", 8'(bus.step), 8'd0);
      cyc(1);  check("clr_irq", 8'(bus.frame_irq), 8'd0);            // cycle 33
      bus.irq_clear = 0;
      cyc(2);  bus.wr_en = 1; bus.wr_data = 8'h80;                   // cycle 35
      cyc(1);  bus.wr_en = 0; lit("imm", 1, 1, 0);                   // cycle 36
      cyc(31); lit("m5_step4", 0, 0, 4);                             // cycle 67
      cyc(8);  lit("m5_step5", 1, 1, 5);                             // cycle 75
      check("m5_irq", 8'(bus.frame_irq), 8'd0);
      cyc(16); lit("wr_step2", 1, 1, 2);                             // cycle 91
      bus.wr_en = 1; bus.wr_data = 8'h00;
      cyc(1);  bus.wr_en = 0; lit("no_imm", 0, 0, 0);                // cycle 92
      cyc(7);  lit("after_wr", 1, 0, 1);                             // cycle 99
      cyc(24); check("m4_irq", 8'(bus.frame_irq), 8'd1);             // cycle 123
      bus.wr_en = 1; bus.wr_data = 8'h40;
      cyc(1);  bus.wr_en = 0;
      check("inh_irq", 8'(bus.frame_irq), 8'd0);                     // cycle 124
      cyc(96); check("inh_3frames_irq", 8'(bus.frame_irq), 8'd0);    // cycle 220
      cyc(20);
      #2 rst_n = 1'b0;
      #1 lit("async_rst", 0, 0, 0);
      check("async_rst_irq", 8'(bus.frame_irq), 8'd0);
      check("async_rst_apu", 8'(bus.apu_clk_en), 8'd0);
      release_reset;
      cyc(7);  lit("post_rst", 1, 0, 1);

      // Randomized writes, acknowledges and occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bus.wr_en     = ($urandom_range(0, 39) == 0);
         bus.wr_data   = 8'($urandom);
         bus.irq_clear = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 699) == 0) begin
            bus.wr_en = 0; bus.irq_clear = 0;
            #2 rst_n = 1'b0;
            release_reset;
         end
      end
      @(negedge clk);
      bus.wr_en = 0; bus.irq_clear = 0;
      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apu_frame_sequencer.md
APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 7457: clk cycles per sequencer step; legal range 2..13107, so that 5*STEP_CYCLES <= 65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port wr_en, input, 1 bit: one-cycle write strobe for the frame-control register.
REQ-005 SHALL have port wr_data, input, 8 bits: bit7 = mode (0 = 4-step, 1 = 5-step); bit6 = irq_inhibit; bits 5:0 ignored.
REQ-006 SHALL have port irq_clear, input, 1 bit: one-cycle status-read acknowledge that clears frame_irq.
REQ-007 SHALL have port apu_clk_en, output, 1 bit: APU-rate enable, high every second clk.
REQ-008 SHALL have port qfr_tick, output, 1 bit: one-cycle quarter-frame enable (envelope units).
REQ-009 SHALL have port hfr_tick, output, 1 bit: one-cycle half-frame enable (length and sweep units).
REQ-010 SHALL have port frame_irq, output, 1 bit: frame interrupt flag, level.
REQ-011 SHALL have port step, output, 3 bits: index of the last step fired (0 = none since frame start).

Function
REQ-012 SHALL keep a 16-bit cycle counter cyc, which increments once per clk.
REQ-013 SHALL fire step k (k = 1..N) in the cycle where cyc == k*STEP_CYCLES-1; N = 4 in 4-step mode and N = 5 in 5-step mode.
REQ-014 SHALL wrap cyc to 0 on the cycle after step N fires; frame length is exactly N*STEP_CYCLES cycles.
REQ-015 In 4-step mode, SHALL assert qfr_tick on steps 1, 2, 3 and 4, and hfr_tick on steps 2 and 4.
REQ-016 In 5-step mode, SHALL assert qfr_tick on steps 1, 2, 3 and 5, and hfr_tick on steps 2 and 5; step 4 produces no tick.
REQ-017 SHALL register qfr_tick and hfr_tick, assert each for exactly one cycle per event, and assert them in the same cycle as the firing step.
REQ-018 SHALL update step in the same cycle as the ticks and return it to 0 when cyc wraps.
REQ-019 SHALL set frame_irq on step 4 in 4-step mode when irq_inhibit = 0; it SHALL never be set in 5-step mode.
REQ-020 SHALL keep frame_irq set until irq_clear is asserted or irq_inhibit is written to 1.
REQ-021 If irq_clear and an IRQ set occur in the same cycle, set SHALL win and frame_irq SHALL remain 1.
REQ-022 On wr_en in cycle T, mode and irq_inhibit SHALL take the new values in cycle T+1, cyc SHALL equal 0 in T+1, and step SHALL equal 0 in T+1.
REQ-023 On a write with bit7 = 1 in cycle T, qfr_tick and hfr_tick SHALL both pulse in cycle T+1 (immediate clock).
REQ-024 On a write with bit7 = 0, no immediate ticks SHALL occur.
REQ-025 On a write with bit6 = 1, frame_irq SHALL be 0 in T+1, overriding any set in cycle T.
REQ-026 A write coinciding with a step-firing cycle SHALL still emit that step's ticks, and the frame restart SHALL take precedence for cycle T+1.
REQ-027 Back-to-back writes SHALL each restart the frame, and the last write SHALL define the mode.
REQ-028 apu_clk_en SHALL be driven from a free-running phase bit, high on odd cycles after reset, and SHALL be unaffected by writes.
REQ-029 irq_clear with frame_irq = 0 SHALL have no effect.

Reset
REQ-030 While rst_n = 0, the block SHALL hold: cyc = 0, mode = 0, irq_inhibit = 0, frame_irq = 0, qfr_tick = 0, hfr_tick = 0, step = 0, apu_clk_en = 0, phase = 0.
REQ-031 Reset assertion SHALL take effect asynchronously, abandoning any frame in progress.
REQ-032 After rst_n deasserts, the first clk edge SHALL begin counting at cyc = 0 in 4-step mode.

Verification (STEP_CYCLES = 8)
REQ-033 4-step mode, no writes after reset -> qfr_tick at cycles 7, 15, 23 and 31; hfr_tick at 15 and 31; frame_irq rises at 31; pattern repeats every 32 cycles.
REQ-034 Write 0x80 at cycle 3 -> qfr_tick and hfr_tick at cycle 4; then qfr_tick at 4+7, +15, +23 and +39; hfr_tick at +15 and +39; no tick at +31; frame_irq stays 0.
REQ-035 frame_irq set, then irq_clear pulsed -> frame_irq = 0 next cycle; irq_clear in the same cycle as step 4 -> frame_irq = 1.
REQ-036 Write 0x40 while frame_irq = 1 -> frame_irq = 0 next cycle and stays 0 across 3 full frames.
REQ-037 Write 0x00 in the step-2 cycle -> that cycle's qfr_tick and hfr_tick present; cyc = 0 next cycle; next qfr_tick 8 cycles later; no immediate tick.
REQ-038 rst_n pulsed low mid-frame (cycle 20) -> all outputs 0 immediately; after release, first qfr_tick 8 cycles later; apu_clk_en toggles with period 2.
